// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-state encoding and architectural constants for the MIPS core
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// pc_register: loadable register with synchronous reset value and load enable
module pc_register #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset to the boot value, otherwise load d only when enabled
    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, addresses the instruction ROM and fills the IF/ID register
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                     DATA_WIDTH   = 32,
    parameter int                     MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC     = DATA_WIDTH'(TEXT_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jump_i,
    input  logic [DATA_WIDTH-1:0] Jump_Target_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] PC_plus4_o,
    output logic                  Valid_o,
    output logic                  Fetch_Fault_o
);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] pc, pc_next, pc_inc, offset;
    logic                  pc_en, pc_bad, capture, bubble, fault_set;

    pc_register #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    // Offset from the text base is computed with wrap-around; PCs below the base are caught separately
    assign pc_inc    = pc + DATA_WIDTH'(4);
    assign offset    = pc - RESET_PC;
    assign Address_o = offset >> 2;
    assign pc_bad    = (pc[1:0] != 2'b00) || (pc < RESET_PC) ||
                       (Address_o >= DATA_WIDTH'(MEMORY_DEPTH));

    // Fetch state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_next;
    end

    // Next state, PC source and IF/ID action; a fault on the current PC outranks every redirect
    always_comb begin
        state_next = state;
        pc_next    = pc_inc;
        pc_en      = 1'b0;
        capture    = 1'b0;
        bubble     = 1'b0;
        fault_set  = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (pc_bad) begin
                    state_next = FAULT;
                    bubble     = 1'b1;
                    fault_set  = 1'b1;
                end else if (Jump_i) begin
                    pc_next = Jump_Target_i;
                    pc_en   = 1'b1;
                    bubble  = 1'b1;
                end else if (Branch_Taken_i) begin
                    pc_next = Branch_Target_i;
                    pc_en   = 1'b1;
                    bubble  = 1'b1;
                end else if (Flush_i) begin
                    pc_en  = !Stall_i;
                    bubble = 1'b1;
                end else if (!Stall_i) begin
                    pc_en   = 1'b1;
                    capture = 1'b1;
                end
            end
            FAULT: state_next = FAULT;
            default: begin
                state_next = FAULT;
                bubble     = 1'b1;
                fault_set  = 1'b1;
            end
        endcase
    end

    // IF/ID pipeline register and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            Instruction_o <= DATA_WIDTH'(NOP_INSTR);
            PC_o          <= '0;
            PC_plus4_o    <= '0;
            Valid_o       <= 1'b0;
            Fetch_Fault_o <= 1'b0;
        end else begin
            if (bubble) begin
                Instruction_o <= DATA_WIDTH'(NOP_INSTR);
                PC_o          <= '0;
                PC_plus4_o    <= '0;
                Valid_o       <= 1'b0;
            end else if (capture) begin
                Instruction_o <= Instruction_i;
                PC_o          <= pc;
                PC_plus4_o    <= pc_inc;
                Valid_o       <= 1'b1;
            end
            if (fault_set)
                Fetch_Fault_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed table, corner sequences and randomized model check of the fetch unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br, jmp;
    logic [31:0] bt, jt, addr, instr_in, instr, pc_o, pc4;
    logic        valid, fault;
    logic [31:0] rom [DEPTH];
    int vectors = 0;
    int miscompares = 0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Stall_i         (stall),
        .Flush_i         (flush),
        .Branch_Taken_i  (br),
        .Branch_Target_i (bt),
        .Jump_i          (jmp),
        .Jump_Target_i   (jt),
        .Address_o       (addr),
        .Instruction_i   (instr_in),
        .Instruction_o   (instr),
        .PC_o            (pc_o),
        .PC_plus4_o      (pc4),
        .Valid_o         (valid),
        .Fetch_Fault_o   (fault)
    );

    always #5 clk = ~clk;

    assign instr_in = (addr < 32'(DEPTH)) ? rom[addr[5:0]] : 32'hDEAD_BEEF;

    typedef struct {
        logic        stall, flush, br, jmp;
        logic [31:0] bt, jt;
        logic        ev;
        logic [31:0] ei, ep, ea;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] btv,
                                input logic j, input logic [31:0] jtv,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ea);
        vec_t v;
        v.stall = s; v.flush = f; v.br = b; v.bt = btv; v.jmp = j; v.jt = jtv;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; br = 0; jmp = 0; bt = 0; jt = 0;
    endtask

    // Reference model: PC and IF/ID contents derived straight from the fetch rules
    logic [31:0] m_pc, m_instr, m_pco;
    logic        m_valid, m_ff, m_boot;

    function automatic bit bad_pc(input logic [31:0] p);
        return (p % 4 != 0) || (p < BASE) || ((p - BASE) / 4 >= DEPTH);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pc = BASE; m_boot = 1; m_valid = 0; m_instr = 0; m_pco = 0; m_ff = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_ff) begin
            if (bad_pc(m_pc)) begin
                m_ff = 1; m_valid = 0; m_instr = 0;
            end else if (jmp || br) begin
                m_pc = jmp ? jt : bt; m_valid = 0; m_instr = 0;
            end else if (flush) begin
                m_valid = 0; m_instr = 0;
                if (!stall) m_pc = m_pc + 4;
            end else if (!stall) begin
                m_instr = rom[(m_pc - BASE) / 4];
                m_pco = m_pc; m_valid = 1; m_pc = m_pc + 4;
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return $urandom;
        if (r == 1) return BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        if (r == 2) return BASE + 4 * DEPTH;
        if (r == 3) return BASE - 4;
        return BASE + 4 * $urandom_range(0, 63);
    endfunction

    initial begin
        int fault_cycles;
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA000_0000 + i;
        idle_inputs();
        reset = 1;
        tick();
        chk("reset valid", 32'(valid), 0);
        chk("reset fault", 32'(fault), 0);
        chk("reset instr", instr, 0);
        chk("reset pc", pc_o, 0);
        chk("reset pc4", pc4, 0);
        chk("reset addr", addr, 0);
        reset = 0;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_0000, 32'h0040_0000, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_0001, 32'h0040_0004, 2);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 32'hA000_0001, 32'h0040_0004, 2);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 32'hA000_0001, 32'h0040_0004, 2);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 32'hA000_0001, 32'h0040_0004, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_0002, 32'h0040_0008, 3);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_0003, 32'h0040_000C, 4);
        tbl[8]  = mk(0, 0, 1, 32'h0040_0020, 1, 32'h0040_0030, 0, 0, 0, 12);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_000C, 32'h0040_0030, 13);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 13);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA000_000D, 32'h0040_0034, 14);
        for (int i = 0; i < 12; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush; br = tbl[i].br;
            bt = tbl[i].bt; jmp = tbl[i].jmp; jt = tbl[i].jt;
            tick();
            chk($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d instr", i), instr, tbl[i].ei);
            chk($sformatf("row%0d addr", i), addr, tbl[i].ea);
            chk($sformatf("row%0d fault", i), 32'(fault), 0);
            if (tbl[i].ev) begin
                chk($sformatf("row%0d pc", i), pc_o, tbl[i].ep);
                chk($sformatf("row%0d pc4", i), pc4, tbl[i].ep + 4);
            end
        end
        idle_inputs();

        jmp = 1; jt = 32'h0040_0002;
        tick();
        idle_inputs();
        chk("misalign bubble valid", 32'(valid), 0);
        chk("misalign bubble fault", 32'(fault), 0);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("fault hold%0d flag", i), 32'(fault), 1);
            chk($sformatf("fault hold%0d valid", i), 32'(valid), 0);
            chk($sformatf("fault hold%0d addr", i), addr, 0);
        end
        reset = 1;
        tick();
        reset = 0;
        chk("fault reset flag", 32'(fault), 0);
        chk("fault reset valid", 32'(valid), 0);
        tick();
        chk("restart boot valid", 32'(valid), 0);
        tick();
        chk("restart valid", 32'(valid), 1);
        chk("restart pc", pc_o, 32'h0040_0000);
        chk("restart instr", instr, 32'hA000_0000);

        jmp = 1; jt = 32'h0040_00F8;
        tick();
        idle_inputs();
        chk("tail bubble addr", addr, 62);
        tick();
        chk("word62 instr", instr, 32'hA000_003E);
        tick();
        chk("word63 valid", 32'(valid), 1);
        chk("word63 instr", instr, 32'hA000_003F);
        chk("word63 pc", pc_o, 32'h0040_00FC);
        chk("word63 fault", 32'(fault), 0);
        tick();
        chk("past end fault", 32'(fault), 1);
        chk("past end valid", 32'(valid), 0);

        reset = 1;
        tick();
        reset = 0;
        repeat (3) tick();
        stall = 1;
        tick();
        chk("stall before reset pc", pc_o, 32'h0040_0004);
        reset = 1;
        tick();
        chk("mid-stall reset valid", 32'(valid), 0);
        chk("mid-stall reset instr", instr, 0);
        chk("mid-stall reset pc", pc_o, 0);
        chk("mid-stall reset pc4", pc4, 0);
        chk("mid-stall reset fault", 32'(fault), 0);
        chk("mid-stall reset addr", addr, 0);

        reset = 1;
        idle_inputs();
        model_step();
        tick();
        reset = 0;
        fault_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 9) == 0);
            jmp   = ($urandom_range(0, 19) == 0);
            bt    = rand_target();
            jt    = rand_target();
            fault_cycles = m_ff ? fault_cycles + 1 : 0;
            reset = (fault_cycles > 4) || ($urandom_range(0, 199) == 0);
            model_step();
            tick();
            chk($sformatf("rnd%0d addr", i), addr, (m_pc - BASE) / 4);
            chk($sformatf("rnd%0d valid", i), 32'(valid), 32'(m_valid));
            chk($sformatf("rnd%0d instr", i), instr, m_instr);
            chk($sformatf("rnd%0d fault", i), 32'(fault), 32'(m_ff));
            if (m_valid) begin
                chk($sformatf("rnd%0d pc", i), pc_o, m_pco);
                chk($sformatf("rnd%0d pc4", i), pc4, m_pco + 4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
